mem_access_stage: RTL

//  MEM pipeline stage of the 8-bit processor. Sits between the EX/MEM pipeline register and the DataMEM block.

---
 rtl/mem_access_stage_if.sv | 28 ++
 rtl/mem_access_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// DataMEM bus between the MEM stage (master) and the data memory (slave).
// Address/strobes/write data come from the stage; read data returns combinationally.
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport master (
    output mem_a,
    output mem_we,
    output mem_re,
    output mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_a,
    input  mem_we,
    input  mem_re,
    input  mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives DataMEM, owns the downward-growing stack pointer,
// sequences two-cycle INT/RTI with an upstream stall and registers MEM/WB results.
module mem_access_stage #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       REG_W    = 2,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [2:0]        op_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] ret_pc_in,
  input  logic [DATA_W-1:0] flags_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              stall_out,
  mem_access_stage_if.master mem,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              pc_load_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flags_load_out,
  output logic [DATA_W-1:0] flags_out
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_INT   = 3'd6;
  localparam logic [2:0] OP_RTI   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT2 = 2'd1,
    ST_RTI2 = 2'd2
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;

  // Stack arithmetic wraps modulo 2^ADDR_W; there is no overflow detection.
  always_comb begin
    sp_inc = sp + ADDR_W'(1);
    sp_dec = sp - ADDR_W'(1);
  end

  // DataMEM drive and stall; everything is forced quiet while reset is held.
  always_comb begin
    mem.mem_a  = sp;
    mem.mem_we = 1'b0;
    mem.mem_re = 1'b0;
    mem.mem_wd = data_in;
    stall_out  = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_IDLE: begin
          if (valid_in) begin
            unique case (op_in)
              OP_LOAD: begin
                mem.mem_a  = addr_in;
                mem.mem_re = 1'b1;
              end
              OP_STORE: begin
                mem.mem_a  = addr_in;
                mem.mem_wd = data_in;
                mem.mem_we = 1'b1;
              end
              OP_PUSH: begin
                mem.mem_a  = sp;
                mem.mem_wd = data_in;
                mem.mem_we = 1'b1;
              end
              OP_POP, OP_RET: begin
                mem.mem_a  = sp_inc;
                mem.mem_re = 1'b1;
              end
              OP_CALL: begin
                mem.mem_a  = sp;
                mem.mem_wd = DATA_W'(ret_pc_in);
                mem.mem_we = 1'b1;
              end
              OP_INT: begin
                mem.mem_a  = sp;
                mem.mem_wd = DATA_W'(ret_pc_in);
                mem.mem_we = 1'b1;
                stall_out  = 1'b1;
              end
              OP_RTI: begin
                mem.mem_a  = sp_inc;
                mem.mem_re = 1'b1;
                stall_out  = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        ST_INT2: begin
          mem.mem_a  = sp;
          mem.mem_wd = flags_in;
          mem.mem_we = 1'b1;
        end
        ST_RTI2: begin
          mem.mem_a  = sp_inc;
          mem.mem_re = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer, stack pointer and MEM/WB register; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      sp             <= SP_RESET;
      valid_out      <= 1'b0;
      wb_en_out      <= 1'b0;
      rd_out         <= '0;
      rd_data_out    <= '0;
      pc_load_out    <= 1'b0;
      pc_out         <= '0;
      flags_load_out <= 1'b0;
      flags_out      <= '0;
    end else begin
      valid_out      <= 1'b0;
      wb_en_out      <= 1'b0;
      pc_load_out    <= 1'b0;
      flags_load_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (valid_in) begin
            rd_out <= rd_in;
            unique case (op_in)
              OP_LOAD: begin
                valid_out   <= 1'b1;
                rd_data_out <= mem.mem_rd;
                wb_en_out   <= 1'b1;
              end
              OP_STORE: begin
                valid_out <= 1'b1;
              end
              OP_PUSH, OP_CALL: begin
                valid_out <= 1'b1;
                sp        <= sp_dec;
              end
              OP_POP: begin
                valid_out   <= 1'b1;
                sp          <= sp_inc;
                rd_data_out <= mem.mem_rd;
                wb_en_out   <= 1'b1;
              end
              OP_RET: begin
                valid_out   <= 1'b1;
                sp          <= sp_inc;
                pc_out      <= ADDR_W'(mem.mem_rd);
                pc_load_out <= 1'b1;
              end
              OP_INT: begin
                sp    <= sp_dec;
                state <= ST_INT2;
              end
              OP_RTI: begin
                // Flags are popped first and held until the PC arrives.
                sp        <= sp_inc;
                flags_out <= mem.mem_rd;
                state     <= ST_RTI2;
              end
              default: begin
              end
            endcase
          end
        end
        ST_INT2: begin
          sp        <= sp_dec;
          valid_out <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RTI2: begin
          sp             <= sp_inc;
          pc_out         <= ADDR_W'(mem.mem_rd);
          pc_load_out    <= 1'b1;
          flags_load_out <= 1'b1;
          valid_out      <= 1'b1;
          state          <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
